// File: rtl/alu_issue_queue.sv
// First-word-fall-through operand/opcode FIFO sitting directly in front of alu_32bit.
// The head entry drives the ALU inputs; ready/valid decouple producer and consumer.
module alu_issue_queue #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [OPW-1:0]           in_opcode,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OPW-1:0]           alu_opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] a_mem  [DEPTH];
    logic [WIDTH-1:0] b_mem  [DEPTH];
    logic [OPW-1:0]   op_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Handshake: a transfer happens on the rising edge where valid & ready are both 1.
    // in_ready depends only on registered state and flush, never on alu_ready, so a
    // full queue refuses a push even in a cycle where the head is being popped.
    assign in_ready  = (cnt != FULL) && !flush;
    assign alu_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = alu_valid && alu_ready;
    assign count     = cnt;

    assign alu_a      = alu_valid ? a_mem[rd_ptr]  : '0;
    assign alu_b      = alu_valid ? b_mem[rd_ptr]  : '0;
    assign alu_opcode = alu_valid ? op_mem[rd_ptr] : '0;

    // Storage is deliberately left out of reset; the zero-gating above hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
            op_mem[wr_ptr] <= in_opcode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && cnt == FULL));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && cnt == '0));

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed and randomized bench for alu_issue_queue, checked cycle by cycle against
// a queue-based model of the FIFO contents.
module tb_alu_issue_queue;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;
    localparam int EW    = 2 * WIDTH + OPW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_opcode;
    logic             alu_valid;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_opcode;
    logic [$clog2(DEPTH):0] count;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model, then clock one edge and advance the model.
    task automatic cycle(input logic v, input logic r, input logic f,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [OPW-1:0] op);
        logic          e_ready;
        logic          e_valid;
        logic [EW-1:0] head;
        in_valid  = v;
        alu_ready = r;
        flush     = f;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        #1;
        e_ready = (exp_q.size() != DEPTH) && !f;
        e_valid = (exp_q.size() != 0);
        head    = e_valid ? exp_q[0] : '0;
        chk("in_ready",   EW'(in_ready),   EW'(e_ready));
        chk("alu_valid",  EW'(alu_valid),  EW'(e_valid));
        chk("count",      EW'(count),      EW'(exp_q.size()));
        chk("alu_a",      EW'(alu_a),      EW'(head[EW-1 -: WIDTH]));
        chk("alu_b",      EW'(alu_b),      EW'(head[OPW +: WIDTH]));
        chk("alu_opcode", EW'(alu_opcode), EW'(head[OPW-1:0]));
        @(posedge clk);
        #1;
        if (f) begin
            exp_q.delete();
        end else begin
            if (e_valid && r) void'(exp_q.pop_front());
            if (v && e_ready) exp_q.push_back({a, b, op});
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_ready = 1'b0;
        in_a = '0; in_b = '0; in_opcode = '0;
        #1;
        chk("reset_valid", EW'(alu_valid), EW'(0));
        chk("reset_count", EW'(count), EW'(0));
        chk("reset_a",     EW'(alu_a), EW'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to DEPTH with no consumer, try a 5th op, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(i), WIDTH'(10 + i), 3'b001);
        chk("full_count", EW'(count), EW'(DEPTH));
        chk("full_ready", EW'(in_ready), EW'(0));
        cycle(1'b1, 1'b0, 1'b0, 32'd4, 32'd14, 3'b001);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", EW'(alu_a), EW'(i));
            cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
        end
        chk("drained_count", EW'(count), EW'(0));

        // Streaming: one push and one pop per cycle.
        for (int n = 0; n < 20; n++) cycle(1'b1, 1'b1, 1'b0, WIDTH'(n), WIDTH'(100 + n), 3'b010);
        chk("stream_count", EW'(count), EW'(1));
        chk("stream_last", EW'(alu_a), EW'(19));
        cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);

        // Full + pop: the push is refused that cycle and accepted on the next.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(200 + i), '0, 3'b011);
        cycle(1'b1, 1'b1, 1'b0, 32'd300, 32'd301, 3'b100);
        chk("fullpop_count", EW'(count), EW'(DEPTH - 1));
        cycle(1'b1, 1'b0, 1'b0, 32'd300, 32'd301, 3'b100);
        chk("fullpush_count", EW'(count), EW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);

        // Pointer wrap with extreme operand values and varying occupancy.
        for (int i = 0; i < 16; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  32'hFFFF_FFFF, 32'd1, 3'($urandom_range(0, 7)));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);

        // Flush with a concurrent push: nothing survives.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(400 + i), '0, 3'b001);
        cycle(1'b1, 1'b1, 1'b1, 32'd999, 32'd999, 3'b111);
        chk("flush_count", EW'(count), EW'(0));
        chk("flush_valid", EW'(alu_valid), EW'(0));
        idle();

        // Asynchronous reset while holding three ops.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(500 + i), '0, 3'b001);
        chk("pre_reset_count", EW'(count), EW'(3));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_valid", EW'(alu_valid), EW'(0));
        chk("async_count", EW'(count), EW'(0));
        chk("async_a",     EW'(alu_a), EW'(0));
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", EW'(in_ready), EW'(1));
        @(posedge clk);
        #1;
        idle();

        // Randomized traffic including occasional flushes.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                  WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
        chk("final_count", EW'(count), EW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
